// File: rtl/bus_arb_pkg.sv
// Shared definitions for the ST memory bus arbiter: owner encoding,
// arbitration state type and the next-owner decision.
package bus_arb_pkg;

  localparam logic [1:0] OWN_CPU = 2'd0;
  localparam logic [1:0] OWN_BLT = 2'd1;
  localparam logic [1:0] OWN_DMA = 2'd2;

  localparam int COOP_SLOTS_DEF = 64;

  typedef enum logic [1:0] {
    ST_CPU      = 2'd0,
    ST_BLT      = 2'd1,
    ST_DMA      = 2'd2,
    ST_HANDOVER = 2'd3
  } arb_state_t;

  // Ownership decision taken at an arbitration point.
  // blt_eff is the blitter request already gated by its rest state.
  function automatic arb_state_t arb_next(arb_state_t cur, logic cpu_as,
                                          logic dma_req, logic blt_eff,
                                          logic blt_req, logic force_release);
    arb_state_t nxt;
    nxt = cur;
    case (cur)
      ST_CPU, ST_HANDOVER: begin
        if (!(dma_req || blt_eff)) nxt = ST_CPU;
        else if (cpu_as)           nxt = ST_HANDOVER;
        else if (dma_req)          nxt = ST_DMA;
        else                       nxt = ST_BLT;
      end
      ST_BLT: begin
        if (dma_req)                        nxt = ST_DMA;
        else if (!blt_req || force_release) nxt = ST_CPU;
        else                                nxt = ST_BLT;
      end
      ST_DMA: begin
        if (dma_req)      nxt = ST_DMA;
        else if (blt_eff) nxt = ST_BLT;
        else              nxt = ST_CPU;
      end
      default: nxt = ST_CPU;
    endcase
    return nxt;
  endfunction

  // Bus owner as seen by the masters; the CPU keeps the bus during HANDOVER.
  function automatic logic [1:0] owner_of(arb_state_t s);
    logic [1:0] own;
    case (s)
      ST_BLT:  own = OWN_BLT;
      ST_DMA:  own = OWN_DMA;
      default: own = OWN_CPU;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/bus_arb_coop.sv
// Blitter cooperative (non-HOG) bus sharing: counts owned slots, forces a
// release after COOP_SLOTS of them, then holds the blitter off for
// COOP_SLOTS slots. Only built when BUS_ARB_COOP_EN is defined.
module bus_arb_coop
  import bus_arb_pkg::*;
#(
  parameter int COOP_SLOTS = COOP_SLOTS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic slot,
  input  logic owned,
  input  logic hog,
  input  logic req,
  input  logic preempted,
  output logic force_release,
  output logic resting,
  output logic eligible
);

  localparam int CW = $clog2(COOP_SLOTS);
  localparam logic [CW-1:0] LAST = CW'(COOP_SLOTS - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);

  // The last owned slot ends here: hand the bus back this arbitration point.
  assign force_release = owned && !hog && !resting && at_last;

  // A rest that ends (or is aborted by HOG) at this arbitration point already
  // lets the blitter compete for the next slot.
  assign eligible = !resting || hog || at_last;

  // Slot counter and rest flag, advanced once per slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      resting <= 1'b0;
    end else if (slot) begin
      if (hog) begin
        cnt     <= '0;
        resting <= 1'b0;
      end else if (resting) begin
        if (at_last) begin
          cnt     <= '0;
          resting <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (!req) begin
        cnt <= '0;
      end else if (owned && !preempted) begin
        if (at_last) begin
          cnt     <= '0;
          resting <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// ST main memory bus arbiter: CPU, blitter and DMA, decided once per
// 4-phase slot at the bus_cycle==3 edge. Priority DMA > blitter > CPU.
// Define BUS_ARB_COOP_EN to build blitter cooperative (non-HOG) sharing;
// without it blt_hog is ignored and blt_resting is tied low.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_CPU      | CPU owns the bus, no pending request
// ST_BLT      | blitter owns the current slot
// ST_DMA      | DMA owns the current slot
// ST_HANDOVER | request pending, CPU still mid-access; re-check each slot
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int COOP_SLOTS = COOP_SLOTS_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] bus_cycle,
  input  logic       cpu_as,
  input  logic       blt_req,
  input  logic       blt_hog,
  input  logic       dma_req,
  output logic       blt_gnt,
  output logic       dma_gnt,
  output logic       cpu_halt,
  output logic [1:0] owner,
  output logic       blt_resting
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       slot;
  logic       force_release;
  logic       blt_ok;
  logic       blt_eff;

  assign slot    = (bus_cycle == 2'd3);
  assign blt_eff = blt_req && blt_ok;

`ifdef BUS_ARB_COOP_EN
  bus_arb_coop #(.COOP_SLOTS(COOP_SLOTS)) u_coop (
    .clk           (clk),
    .reset_n       (reset_n),
    .slot          (slot),
    .owned         (state == ST_BLT),
    .hog           (blt_hog),
    .req           (blt_req),
    .preempted     (state == ST_DMA),
    .force_release (force_release),
    .resting       (blt_resting),
    .eligible      (blt_ok)
  );
`else
  localparam int coop_slots_unused = COOP_SLOTS;
  logic blt_hog_unused;
  assign blt_hog_unused = blt_hog;
  assign force_release  = 1'b0;
  assign blt_resting    = 1'b0;
  assign blt_ok         = 1'b1;
`endif

  assign state_nxt = arb_next(state, cpu_as, dma_req, blt_eff, blt_req,
                              force_release);

  // Ownership FSM with registered grants; halt is refreshed every clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CPU;
      owner    <= OWN_CPU;
      blt_gnt  <= 1'b0;
      dma_gnt  <= 1'b0;
      cpu_halt <= 1'b0;
    end else begin
      cpu_halt <= (owner != OWN_CPU) || dma_req || (blt_req && !blt_resting);
      if (slot) begin
        state   <= state_nxt;
        owner   <= owner_of(state_nxt);
        blt_gnt <= (state_nxt == ST_BLT);
        dma_gnt <= (state_nxt == ST_DMA);
      end
    end
  end

endmodule
